// File: rtl/sw_run_ctrl_if.sv
// sw_run_ctrl_if: host command, core result stream and summary FIFO signals of sw_run_ctrl.
// slave is the controller side, master is the host/core side.
interface sw_run_ctrl_if #(
   parameter int CALC_BIT  = 16,
   parameter int T_IDX_BIT = 8,
   parameter int Q_CNT_BIT = 8
);
   logic                 cmd_valid_i;
   logic                 cmd_ready_o;
   logic [Q_CNT_BIT-1:0] cmd_nq_i;
   logic                 sw_start_o;
   logic                 sw_busy_i;
   logic                 sw_valid_i;
   logic                 sw_change_q_i;
   logic [T_IDX_BIT-1:0] sw_match_idx_i;
   logic [CALC_BIT-1:0]  sw_max_result_i;
   logic                 res_valid_o;
   logic                 res_ready_i;
   logic [Q_CNT_BIT-1:0] res_q_idx_o;
   logic [T_IDX_BIT-1:0] res_t_idx_o;
   logic [CALC_BIT-1:0]  res_score_o;
   logic [T_IDX_BIT-1:0] res_t_cnt_o;
   logic                 done_o;
   logic                 err_o;
   logic [2:0]           err_code_o;
   modport slave (
      input  cmd_valid_i, cmd_nq_i, sw_busy_i, sw_valid_i, sw_change_q_i, sw_match_idx_i, sw_max_result_i, res_ready_i,
      output cmd_ready_o, sw_start_o, res_valid_o, res_q_idx_o, res_t_idx_o, res_score_o, res_t_cnt_o, done_o, err_o,
             err_code_o
   );
   modport master (
      output cmd_valid_i, cmd_nq_i, sw_busy_i, sw_valid_i, sw_change_q_i, sw_match_idx_i, sw_max_result_i, res_ready_i,
      input  cmd_ready_o, sw_start_o, res_valid_o, res_q_idx_o, res_t_idx_o, res_score_o, res_t_cnt_o, done_o, err_o,
             err_code_o
   );
endinterface

// File: rtl/sw_run_ctrl.sv
// sw_run_ctrl: starts a SmithWaterman run, tracks its result stream and queues one summary per query in a FIFO.
module sw_run_ctrl #(
   parameter int CALC_BIT   = 16,
   parameter int T_IDX_BIT  = 8,
   parameter int Q_CNT_BIT  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int WDOG_CYC   = 50000
) (
   input logic          clk,
   input logic          rst,
   sw_run_ctrl_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(WDOG_CYC + 1);
   typedef enum logic [2:0] {IDLE, START, WAIT, RUN, DONE} state_t;
   typedef struct packed {
      logic [Q_CNT_BIT-1:0] q;
      logic [T_IDX_BIT-1:0] t;
      logic [CALC_BIT-1:0]  s;
      logic [T_IDX_BIT-1:0] c;
   } ent_t;
   state_t               state;
   ent_t                 mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [PW:0]          cnt;
   logic [Q_CNT_BIT-1:0] nq, q_idx, q_nxt;
   logic [T_IDX_BIT-1:0] t_cnt, t_inc;
   logic [WW-1:0]        wdog;
   logic [2:0]           err_code;
   logic                 trk, beat, push, pop, full, wr_en, tmo;
   always_comb begin
      trk   = state == WAIT || state == RUN;
      beat  = trk && bus.sw_valid_i;
      push  = beat && bus.sw_change_q_i;
      pop   = cnt != '0 && bus.res_ready_i;
      full  = cnt == (PW+1)'(FIFO_DEPTH);
      wr_en = push && (!full || pop);
      t_inc = &t_cnt ? t_cnt : t_cnt + 1'b1;
      q_nxt = push ? q_idx + 1'b1 : q_idx;
      // the start cycle counts toward the watchdog, so start->first valid is covered
      tmo   = (state == START || trk) && !beat && wdog == WW'(WDOG_CYC - 1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bus.cmd_ready_o <= 1'b1;
         bus.sw_start_o  <= 1'b0;
         bus.done_o      <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         cnt             <= '0;
         nq              <= '0;
         q_idx           <= '0;
         t_cnt           <= '0;
         wdog            <= '0;
         err_code        <= '0;
      end else begin
         bus.sw_start_o <= 1'b0;
         bus.done_o     <= 1'b0;
         if (wr_en) begin
            mem[wr_ptr] <= '{q_idx, bus.sw_match_idx_i, bus.sw_max_result_i, t_inc};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (PW+1)'(wr_en) - (PW+1)'(pop);
         if (push && full && !pop) err_code[1] <= 1'b1;
         if (beat) begin
            q_idx <= q_nxt;
            t_cnt <= push ? '0 : t_inc;
         end
         if (state == START || trk) wdog <= beat ? '0 : wdog + 1'b1;
         case (state)
            IDLE: if (bus.cmd_valid_i) begin
               nq              <= bus.cmd_nq_i;
               err_code        <= '0;
               q_idx           <= '0;
               t_cnt           <= '0;
               wdog            <= '0;
               bus.cmd_ready_o <= 1'b0;
               if (bus.cmd_nq_i == '0) begin
                  state      <= DONE;
                  bus.done_o <= 1'b1;
               end else begin
                  state          <= START;
                  bus.sw_start_o <= 1'b1;
               end
            end
            START: state <= WAIT;
            WAIT: if (bus.sw_busy_i) state <= RUN;
            RUN: if (!bus.sw_busy_i && !tmo) begin
               state      <= DONE;
               bus.done_o <= 1'b1;
               if (q_nxt != nq) err_code[2] <= 1'b1;
            end
            DONE: begin
               state           <= IDLE;
               bus.cmd_ready_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
         if (tmo) begin
            err_code[0] <= 1'b1;
            state       <= DONE;
            bus.done_o  <= 1'b1;
         end
      end
   end
   assign bus.res_valid_o = cnt != '0;
   assign bus.res_q_idx_o = mem[rd_ptr].q;
   assign bus.res_t_idx_o = mem[rd_ptr].t;
   assign bus.res_score_o = mem[rd_ptr].s;
   assign bus.res_t_cnt_o = mem[rd_ptr].c;
   assign bus.err_code_o  = err_code;
   assign bus.err_o       = |err_code;
endmodule

// File: tb/tb_sw_run_ctrl.sv
// tb_sw_run_ctrl: directed runs of sw_run_ctrl with a simple core model and a queue of expected summaries.
module tb_sw_run_ctrl;
   localparam int DEPTH = 4;
   typedef struct {
      logic [7:0]  q;
      logic [7:0]  t;
      logic [15:0] s;
      logic [7:0]  c;
   } ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0, checks = 0, done_cnt = 0, mq = 0;
   ent_t exp_q[$];
   logic [2:0] exp_err = 3'b000;
   sw_run_ctrl_if #(.CALC_BIT(16), .T_IDX_BIT(8), .Q_CNT_BIT(8)) bus ();
   sw_run_ctrl #(.CALC_BIT(16), .T_IDX_BIT(8), .Q_CNT_BIT(8), .FIFO_DEPTH(DEPTH), .WDOG_CYC(100)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.done_o === 1'b1) done_cnt <= done_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag);
      chk({tag, ".valid"}, 32'(bus.res_valid_o), 32'd1);
      chk({tag, ".q_idx"}, 32'(bus.res_q_idx_o), 32'(exp_q[0].q));
      chk({tag, ".t_idx"}, 32'(bus.res_t_idx_o), 32'(exp_q[0].t));
      chk({tag, ".score"}, 32'(bus.res_score_o), 32'(exp_q[0].s));
      chk({tag, ".t_cnt"}, 32'(bus.res_t_cnt_o), 32'(exp_q[0].c));
   endtask

   task automatic issue(input int nq);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_nq_i    = 8'(nq);
      mq              = 0;
      exp_err         = 3'b000;
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask

   // one query: nt result beats, change_q on the last; fields on earlier beats are decoys
   task automatic query(input int idx, input int score, input int nt, input bit pop_last);
      ent_t e;
      for (int i = 0; i < nt; i++) begin
         bus.sw_valid_i      = 1'b1;
         bus.sw_change_q_i   = (i == nt - 1);
         bus.sw_match_idx_i  = (i == nt - 1) ? 8'(idx) : 8'hEE;
         bus.sw_max_result_i = (i == nt - 1) ? 16'(score) : 16'hDEAD;
         if (i == nt - 1 && pop_last) begin
            chk_head("pop_same_cycle");
            bus.res_ready_i = 1'b1;
         end
         tick();
         bus.res_ready_i = 1'b0;
      end
      bus.sw_valid_i    = 1'b0;
      bus.sw_change_q_i = 1'b0;
      chk("res_valid_latency", 32'(bus.res_valid_o), 32'd1);
      e = '{8'(mq), 8'(idx), 16'(score), 8'(nt > 255 ? 255 : nt)};
      if (pop_last) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) exp_q.push_back(e);
      else exp_err[1] = 1'b1;
      mq++;
      tick();
   endtask

   task automatic begin_run(input string tag);
      chk({tag, ".start"}, 32'(bus.sw_start_o), 32'd1);
      chk({tag, ".ready"}, 32'(bus.cmd_ready_o), 32'd0);
      bus.sw_busy_i = 1'b1;
      tick();
      chk({tag, ".start_pulse"}, 32'(bus.sw_start_o), 32'd0);
      repeat (2) tick();
   endtask

   task automatic end_run(input string tag);
      int d0;
      d0 = done_cnt;
      bus.sw_busy_i = 1'b0;
      tick();
      chk({tag, ".done"}, 32'(bus.done_o), 32'd1);
      chk({tag, ".err_code"}, 32'(bus.err_code_o), 32'(exp_err));
      chk({tag, ".err"}, 32'(bus.err_o), 32'(|exp_err));
      tick();
      chk({tag, ".done_low"}, 32'(bus.done_o), 32'd0);
      chk({tag, ".done_once"}, 32'(done_cnt), 32'(d0 + 1));
      chk({tag, ".ready_back"}, 32'(bus.cmd_ready_o), 32'd1);
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         chk_head(tag);
         bus.res_ready_i = 1'b1;
         tick();
         bus.res_ready_i = 1'b0;
         void'(exp_q.pop_front());
      end
      chk({tag, ".empty"}, 32'(bus.res_valid_o), 32'd0);
   endtask

   initial begin
      int n, d0;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_nq_i = '0;
      bus.sw_busy_i = 1'b0;
      bus.sw_valid_i = 1'b0;
      bus.sw_change_q_i = 1'b0;
      bus.sw_match_idx_i = '0;
      bus.sw_max_result_i = '0;
      bus.res_ready_i = 1'b0;
      repeat (2) tick();
      chk("rst.ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("rst.start", 32'(bus.sw_start_o), 32'd0);
      chk("rst.done", 32'(bus.done_o), 32'd0);
      chk("rst.err", 32'(bus.err_o), 32'd0);
      chk("rst.err_code", 32'(bus.err_code_o), 32'd0);
      chk("rst.res_valid", 32'(bus.res_valid_o), 32'd0);
      rst = 1'b0;
      tick();
      // two queries of three targets each
      issue(2);
      begin_run("t1");
      query(3, 9, 3, 1'b0);
      repeat (5) tick();
      query(4, 14, 3, 1'b0);
      end_run("t1");
      drain("t1");
      // six queries into a four-deep FIFO with nobody popping
      issue(6);
      begin_run("t2");
      for (int q = 0; q < 6; q++) query(q + 10, q * 3 + 1, 2, 1'b0);
      end_run("t2");
      drain("t2");
      // core never answers: watchdog fires
      issue(1);
      chk("t3.start", 32'(bus.sw_start_o), 32'd1);
      n = 0;
      while (bus.err_o !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk("t3.wdog_cycles", 32'(n), 32'd100);
      chk("t3.err_code", 32'(bus.err_code_o), 32'b001);
      chk("t3.done", 32'(bus.done_o), 32'd1);
      tick();
      chk("t3.ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("t3.empty", 32'(bus.res_valid_o), 32'd0);
      // query-count mismatch; also target-count saturation
      issue(3);
      chk("t4.err_cleared", 32'(bus.err_code_o), 32'd0);
      begin_run("t4");
      query(2, 20, 1, 1'b0);
      query(7, 50, 300, 1'b0);
      exp_err[2] = 1'b1;
      end_run("t4");
      drain("t4");
      // zero-query command
      d0 = done_cnt;
      issue(0);
      chk("t5.no_start", 32'(bus.sw_start_o), 32'd0);
      chk("t5.done", 32'(bus.done_o), 32'd1);
      tick();
      chk("t5.done_low", 32'(bus.done_o), 32'd0);
      chk("t5.ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("t5.err_code", 32'(bus.err_code_o), 32'd0);
      chk("t5.done_once", 32'(done_cnt), 32'(d0 + 1));
      // reset in the middle of a run
      issue(2);
      begin_run("t6");
      query(1, 5, 2, 1'b0);
      d0 = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.sw_busy_i = 1'b0;
      exp_q.delete();
      chk("t6.res_valid", 32'(bus.res_valid_o), 32'd0);
      chk("t6.ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("t6.start", 32'(bus.sw_start_o), 32'd0);
      chk("t6.err_code", 32'(bus.err_code_o), 32'd0);
      repeat (3) tick();
      chk("t6.no_done", 32'(done_cnt), 32'(d0));
      // full FIFO with push and pop in the same cycle
      issue(5);
      begin_run("t7");
      for (int q = 0; q < 4; q++) query(q + 20, q + 100, 1, 1'b0);
      query(30, 200, 2, 1'b1);
      end_run("t7");
      drain("t7");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
